// File: rtl/imm_pkg.sv
// Shared immediate-type select encodings for the RV32 decode stage.
// Imported by the immediate generator and by the decoder/control unit.
package imm_pkg;

    localparam logic [2:0] IMM_U    = 3'b000;
    localparam logic [2:0] IMM_J    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_I    = 3'b011;
    localparam logic [2:0] IMM_IU   = 3'b100;
    localparam logic [2:0] IMM_S    = 3'b101;
    localparam logic [2:0] IMM_SFT  = 3'b110;
    localparam logic [2:0] IMM_RSVD = 3'b111;

endpackage

// File: rtl/immediate_generate.sv
// RV32IM immediate generator: combinational immediate from instr[31:7]
// plus a registered copy for the ID/EX pipeline register.
// Optional macro IMM_ILLEGAL_SEL_EN adds the ILLEGAL_SEL flag output.
module immediate_generate
    import imm_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [24:0] IN,       // IN[i] = instr[i+7]
    input  logic [2:0]  IMM_SEL,
    output logic [31:0] OUT,
    output logic [31:0] OUT_REG
`ifdef IMM_ILLEGAL_SEL_EN
    ,
    output logic        ILLEGAL_SEL
`endif
);

    logic s_bit;
    assign s_bit = IN[24];

    // Immediate mux; constant bits are literal so X/Z on IN cannot reach them.
    always_comb begin
        OUT = 32'h0000_0000;
        case (IMM_SEL)
            IMM_U:   OUT = {IN[24:5], 12'b0};
            IMM_J:   OUT = {{12{s_bit}}, IN[12:5], IN[13], IN[23:14], 1'b0};
            IMM_B:   OUT = {{20{s_bit}}, IN[0], IN[23:18], IN[4:1], 1'b0};
            IMM_I:   OUT = {{20{s_bit}}, IN[24:13]};
            IMM_IU:  OUT = {20'b0, IN[24:13]};
            IMM_S:   OUT = {{20{s_bit}}, IN[24:18], IN[4:0]};
            IMM_SFT: OUT = {27'b0, IN[17:13]};
            default: OUT = 32'h0000_0000;   // reserved select
        endcase
    end

`ifdef IMM_ILLEGAL_SEL_EN
    // Flag the reserved select; OUT is already forced to zero for it.
    assign ILLEGAL_SEL = (IMM_SEL == IMM_RSVD);
`endif

    // Registered copy of the immediate; synchronous clear.
    always_ff @(posedge CLK) begin
        if (RESET) OUT_REG <= 32'h0000_0000;
        else       OUT_REG <= OUT;
    end

endmodule

// File: tb/tb_immediate_generate.sv
// Table-driven self-checking bench for immediate_generate.
module tb_immediate_generate;
    import imm_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [24:0] IN;
    logic [2:0]  IMM_SEL;
    logic [31:0] OUT;
    logic [31:0] OUT_REG;
`ifdef IMM_ILLEGAL_SEL_EN
    logic        ILLEGAL_SEL;
`endif

    int checks = 0;
    int errors = 0;

    immediate_generate dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IN      (IN),
        .IMM_SEL (IMM_SEL),
        .OUT     (OUT),
        .OUT_REG (OUT_REG)
`ifdef IMM_ILLEGAL_SEL_EN
        ,
        .ILLEGAL_SEL (ILLEGAL_SEL)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [24:0] in;
        logic [2:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    localparam logic [24:0] IN_U   = 25'b1011000000111000100010100;
    localparam logic [24:0] IN_J   = 25'b1000110111010100111001010;
    localparam logic [24:0] IN_B   = 25'b1010000110111010111001010;
    localparam logic [24:0] IN_I   = 25'b1010010010011010001000101;
    localparam logic [24:0] IN_INV = 25'b1010010010010101110111010; // I field same, low 13 flipped

    initial begin
        vecs.push_back('{"u",        IN_U,   IMM_U,    32'hB038_8000});
        vecs.push_back('{"j",        IN_J,   IMM_J,    32'hFFF4_E8DC});
        vecs.push_back('{"b",        IN_B,   IMM_B,    32'hFFFF_F20A});
        vecs.push_back('{"i",        IN_I,   IMM_I,    32'hFFFF_FA49});
        vecs.push_back('{"iu",       IN_I,   IMM_IU,   32'h0000_0A49});
        vecs.push_back('{"s",        IN_I,   IMM_S,    32'hFFFF_FA45});
        vecs.push_back('{"sft",      IN_I,   IMM_SFT,  32'h0000_0009});
        vecs.push_back('{"i_unused", IN_INV, IMM_I,    32'hFFFF_FA49});
        vecs.push_back('{"i_pos",    25'b0111111111110000000000000, IMM_I, 32'h0000_07FF});
        vecs.push_back('{"b_bit11",  25'h000_0001, IMM_B,  32'h0000_0800});
        vecs.push_back('{"j_bit11",  25'h000_2000, IMM_J,  32'h0000_0800});
        vecs.push_back('{"u_ones",   25'h1FF_FFFF, IMM_U,  32'hFFFF_F000});
        vecs.push_back('{"iu_ones",  25'h1FF_FFFF, IMM_IU, 32'h0000_0FFF});
        vecs.push_back('{"s_ones",   25'h1FF_FFFF, IMM_S,  32'hFFFF_FFFF});
        vecs.push_back('{"sft_ones", 25'h1FF_FFFF, IMM_SFT,32'h0000_001F});
        vecs.push_back('{"rsvd_a",   25'h1FF_FFFF, IMM_RSVD, 32'h0});
        vecs.push_back('{"rsvd_b",   IN_I,         IMM_RSVD, 32'h0});

        // Reset: OUT_REG clears, OUT still follows inputs.
        RESET   = 1'b1;
        IN      = IN_U;
        IMM_SEL = IMM_U;
        @(posedge CLK); #1;
        check32("reset_out_reg", OUT_REG, 32'h0);
        check32("reset_out_comb", OUT, 32'hB038_8000);

        // Release reset, I case appears on OUT_REG after the next edge.
        RESET   = 1'b0;
        IN      = IN_I;
        IMM_SEL = IMM_I;
        @(posedge CLK); #1;
        check32("reg_i", OUT_REG, 32'hFFFF_FA49);

        // Table: OUT immediately, OUT_REG after the following edge.
        foreach (vecs[k]) begin
            IN      = vecs[k].in;
            IMM_SEL = vecs[k].sel;
            #1;
            check32({vecs[k].name, "_out"}, OUT, vecs[k].exp);
`ifdef IMM_ILLEGAL_SEL_EN
            check1({vecs[k].name, "_illegal"}, ILLEGAL_SEL, vecs[k].sel == IMM_RSVD);
`endif
            @(posedge CLK); #1;
            check32({vecs[k].name, "_reg"}, OUT_REG, vecs[k].exp);
        end

        // Mid-stream reset: register clears on that edge, OUT keeps tracking.
        IN      = IN_J;
        IMM_SEL = IMM_J;
        @(posedge CLK); #1;
        check32("pre_rst_reg", OUT_REG, 32'hFFF4_E8DC);
        RESET   = 1'b1;
        IN      = IN_B;
        IMM_SEL = IMM_B;
        @(posedge CLK); #1;
        check32("mid_rst_reg", OUT_REG, 32'h0);
        check32("mid_rst_out", OUT, 32'hFFFF_F20A);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check32("post_rst_reg", OUT_REG, 32'hFFFF_F20A);

        // Select change alone with IN fixed.
        IN      = IN_I;
        IMM_SEL = IMM_S;
        #1;
        check32("sel_change_out", OUT, 32'hFFFF_FA45);
        check1("sel_change_sign", OUT[31], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
